// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the four-port AXI read arbiter: requester count,
// AXI ID width and the arbiter state encoding.
package axi_rd_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } state_t;

endpackage

// File: rtl/axi_rd_arbiter_rr_pick.sv
// Combinational round-robin picker for four requesters. The search starts at
// index ptr and wraps 3->0; the first asserted request wins.
module rr_pick_4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] grant,
    output logic [1:0] idx,
    output logic       any
);

    logic       found;
    logic [1:0] cand;

    // Walk the four candidates in priority order starting at ptr.
    always_comb begin
        grant = '0;
        idx   = ptr;
        found = 1'b0;
        cand  = ptr;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter that funnels four single-burst read requesters onto one
// AXI read channel. One transaction is outstanding at a time; the winner's
// index and address are captured at grant time and drive AR until the burst
// ends with rlast.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int NUM_REQ = axi_rd_arbiter_pkg::NUM_REQ,
    parameter int ID_W    = axi_rd_arbiter_pkg::ID_W
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [32*NUM_REQ-1:0]   req_addr,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [31:0]             resp_data,
    output logic                    resp_last,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [31:0]             araddr,
    output logic [ID_W-1:0]         arid,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [31:0]             rdata,
    input  logic [ID_W-1:0]         rid,
    input  logic                    rlast,
    output logic                    err_rid
);

    state_t               state;
    state_t               state_nx;
    logic [1:0]           ptr;
    logic [1:0]           g;
    logic [31:0]          araddr_q;
    logic                 err_q;
    logic [3:0]           pick_grant;
    logic [1:0]           pick_idx;
    logic                 pick_any;
    logic [31:0]          sel_addr;
    logic [NUM_REQ-1:0]   g_oh;

    rr_pick_4 u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Select the winning requester's address using the one-hot grant.
    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_addr = req_addr[32*i +: 32];
            end
        end
    end

    // One-hot view of the registered grant index for routing.
    always_comb begin
        g_oh    = '0;
        g_oh[g] = 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: grant, wait for the AR handshake, then wait for the last beat.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (pick_any)         state_nx = ST_AR;
            ST_AR:   if (arready)          state_nx = ST_R;
            ST_R:    if (rvalid && rlast)  state_nx = ST_IDLE;
            default:                       state_nx = ST_IDLE;
        endcase
    end

    // Transaction registers: captured grant, address, rotating pointer, ID error.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            g        <= 2'd0;
            araddr_q <= 32'd0;
            ptr      <= 2'd0;
            err_q    <= 1'b0;
        end else begin
            if (state == ST_IDLE && pick_any) begin
                g        <= pick_idx;
                araddr_q <= sel_addr;
            end
            if (state == ST_AR && arready) begin
                ptr <= g + 2'd1;
            end
            if (state == ST_R && rvalid && (rid != arid)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Outputs decoded from the current state; R-channel routing is combinational.
    always_comb begin
        arvalid    = 1'b0;
        rready     = 1'b0;
        req_ready  = '0;
        resp_valid = '0;
        resp_last  = 1'b0;
        case (state)
            ST_AR: begin
                arvalid = 1'b1;
                if (arready) req_ready = g_oh;
            end
            ST_R: begin
                rready    = 1'b1;
                if (rvalid) resp_valid = g_oh;
                resp_last = rlast & rvalid;
            end
            default: ;
        endcase
    end

    assign araddr    = araddr_q;
    assign arid      = ID_W'(g);
    assign resp_data = rdata;
    assign err_rid   = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: a directed vector table, hand-written
// corner-case sequences and a randomized phase, all compared every cycle
// against a transaction-level model of the arbiter.
module tb_axi_rd_arbiter;

    localparam int ID_W = 4;

    logic            clk = 1'b0;
    logic            resetn;
    logic [3:0]      req_valid;
    logic [127:0]    req_addr;
    logic [3:0]      req_ready;
    logic [3:0]      resp_valid;
    logic [31:0]     resp_data;
    logic            resp_last;
    logic            arvalid;
    logic            arready;
    logic [31:0]     araddr;
    logic [ID_W-1:0] arid;
    logic            rvalid;
    logic            rready;
    logic [31:0]     rdata;
    logic [ID_W-1:0] rid;
    logic            rlast;
    logic            err_rid;

    axi_rd_arbiter #(.NUM_REQ(4), .ID_W(ID_W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_last  (resp_last),
        .arvalid    (arvalid),
        .arready    (arready),
        .araddr     (araddr),
        .arid       (arid),
        .rvalid     (rvalid),
        .rready     (rready),
        .rdata      (rdata),
        .rid        (rid),
        .rlast      (rlast),
        .err_rid    (err_rid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Transaction-level model: is a burst in flight, has its address been
    // accepted, who owns it, where the next search starts, sticky ID error.
    bit          m_busy;
    bit          m_addr_done;
    bit          m_err;
    int          m_win;
    int          m_ptr;
    logic [31:0] m_addr;
    logic [3:0]  accepted;

    typedef struct {
        logic [3:0]  rv;
        logic        ar;
        logic        vld;
        logic        lst;
        logic [3:0]  id;
        logic [31:0] data;
        logic        exp_arvalid;
        logic [3:0]  exp_req_ready;
        logic        exp_rready;
        logic [3:0]  exp_resp_valid;
        logic        exp_resp_last;
        logic [3:0]  exp_arid;
        logic [31:0] exp_araddr;
    } vec_t;

    vec_t vecs[5];

    // Compare one observed value with its expected value and tally the result.
    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Return the model to its post-reset condition.
    task automatic modelReset();
        m_busy      = 0;
        m_addr_done = 0;
        m_err       = 0;
        m_win       = 0;
        m_ptr       = 0;
        m_addr      = '0;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic modelUpdate();
        int w;
        if (!m_busy) begin
            w = -1;
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && req_valid[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            end
            if (w >= 0) begin
                m_busy      = 1;
                m_addr_done = 0;
                m_win       = w;
                m_addr      = req_addr[w*32 +: 32];
            end
        end else if (!m_addr_done) begin
            if (arready) begin
                m_addr_done = 1;
                m_ptr       = (m_win + 1) % 4;
            end
        end else begin
            if (rvalid && (int'(rid) != m_win)) m_err = 1;
            if (rvalid && rlast) m_busy = 0;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] rv, input logic ar, input logic vld,
                                 input logic lst, input logic [3:0] id, input logic [31:0] data);
        req_valid = rv;
        arready   = ar;
        rvalid    = vld;
        rlast     = lst;
        rid       = id;
        rdata     = data;
    endtask

    // Compare every DUT output with what the model predicts for the current inputs.
    task automatic checkOutput();
        bit in_ar;
        bit in_r;
        in_ar = m_busy && !m_addr_done;
        in_r  = m_busy && m_addr_done;
        check_eq("arvalid",    32'(arvalid),    32'(in_ar));
        check_eq("araddr",     araddr,          m_addr);
        check_eq("arid",       32'(arid),       32'(m_win));
        check_eq("req_ready",  32'(req_ready),  32'((in_ar && arready) ? onehot(m_win) : 4'b0));
        check_eq("rready",     32'(rready),     32'(in_r));
        check_eq("resp_valid", 32'(resp_valid), 32'((in_r && rvalid) ? onehot(m_win) : 4'b0));
        check_eq("resp_last",  32'(resp_last),  32'(in_r && rvalid && rlast));
        if (in_r) check_eq("resp_data", resp_data, rdata);
        check_eq("err_rid",    32'(err_rid),    32'(m_err));
    endtask

    task automatic checkRow(input int r);
        check_eq($sformatf("vec%0d_arvalid", r),    32'(arvalid),    32'(vecs[r].exp_arvalid));
        check_eq($sformatf("vec%0d_req_ready", r),  32'(req_ready),  32'(vecs[r].exp_req_ready));
        check_eq($sformatf("vec%0d_rready", r),     32'(rready),     32'(vecs[r].exp_rready));
        check_eq($sformatf("vec%0d_resp_valid", r), 32'(resp_valid), 32'(vecs[r].exp_resp_valid));
        check_eq($sformatf("vec%0d_resp_last", r),  32'(resp_last),  32'(vecs[r].exp_resp_last));
        check_eq($sformatf("vec%0d_arid", r),       32'(arid),       32'(vecs[r].exp_arid));
        check_eq($sformatf("vec%0d_araddr", r),     araddr,          vecs[r].exp_araddr);
    endtask

    // One clock: check at the falling edge, advance the model at the rising
    // edge, then let accepted requesters drop their request.
    task automatic stepCycle(input int row = -1);
        @(negedge clk);
        checkOutput();
        if (row >= 0) checkRow(row);
        accepted = req_ready;
        @(posedge clk);
        modelUpdate();
        #1;
        req_valid = req_valid & ~accepted;
    endtask

    initial begin
        int n_grant;
        int budget;

        vecs[0] = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,
                    1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'd0, 32'h0};
        vecs[1] = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0,
                    1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 4'd2, 32'h1C00_0040};
        vecs[2] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'd2, 32'hDEAD_0001,
                    1'b0, 4'b0000, 1'b1, 4'b0100, 1'b0, 4'd2, 32'h1C00_0040};
        vecs[3] = '{4'b0000, 1'b0, 1'b1, 1'b1, 4'd2, 32'hDEAD_0002,
                    1'b0, 4'b0000, 1'b1, 4'b0100, 1'b1, 4'd2, 32'h1C00_0040};
        vecs[4] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0,
                    1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'd2, 32'h1C00_0040};

        resetn   = 1'b1;
        accepted = '0;
        req_addr = {32'h3000_0300, 32'h1C00_0040, 32'h2000_0100, 32'h0000_1000};
        applyStimulus(4'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        modelReset();
        #1 resetn = 1'b0;
        #2;
        checkOutput();
        @(posedge clk);
        #1 resetn = 1'b1;

        $display("[TB] directed vector table");
        for (int r = 0; r < 5; r++) begin
            applyStimulus(vecs[r].rv, vecs[r].ar, vecs[r].vld, vecs[r].lst, vecs[r].id, vecs[r].data);
            stepCycle(r);
        end

        $display("[TB] arready stall");
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        stepCycle();
        for (int c = 0; c < 5; c++) begin
            applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
            stepCycle();
            check_eq("stall_arvalid", 32'(arvalid), 32'd1);
            check_eq("stall_araddr", araddr, 32'h0000_1000);
            check_eq("stall_req_ready", 32'(req_ready), 32'd0);
        end
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0);
        stepCycle();
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1, 4'd0, 32'h1111_0000);
        stepCycle();
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        stepCycle();

        $display("[TB] late request during R phase");
        applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        stepCycle();
        applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0);
        stepCycle();
        applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0, 4'd1, 32'h0);
        stepCycle();
        check_eq("late_keep_arid", 32'(arid), 32'd1);
        applyStimulus(4'b1000, 1'b0, 1'b1, 1'b0, 4'd1, 32'h2222_0001);
        stepCycle();
        applyStimulus(4'b1000, 1'b0, 1'b1, 1'b1, 4'd1, 32'h2222_0002);
        stepCycle();
        applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        stepCycle();
        check_eq("late_winner_arid", 32'(arid), 32'd3);
        check_eq("late_winner_arvalid", 32'(arvalid), 32'd1);
        applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0);
        stepCycle();
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1, 4'd3, 32'h3333_0000);
        stepCycle();
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        stepCycle();

        $display("[TB] mismatched rid");
        applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        stepCycle();
        applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0);
        stepCycle();
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 4'd3, 32'h4444_0001);
        stepCycle();
        check_eq("err_rid_set", 32'(err_rid), 32'd1);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1, 4'd1, 32'h4444_0002);
        stepCycle();
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        stepCycle();
        check_eq("err_rid_sticky", 32'(err_rid), 32'd1);

        $display("[TB] reset mid-burst");
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        stepCycle();
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0);
        stepCycle();
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 4'd2, 32'h5555_0001);
        stepCycle();
        #2 resetn = 1'b0;
        #1;
        modelReset();
        checkOutput();
        check_eq("rst_rready", 32'(rready), 32'd0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_err_rid", 32'(err_rid), 32'd0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        @(posedge clk);
        #1 resetn = 1'b1;

        $display("[TB] all requesters continuously active");
        n_grant = 0;
        budget  = 0;
        while (n_grant < 8 && budget < 200) begin
            applyStimulus(4'b1111, 1'b1, 1'b1, 1'b1, 4'(m_win), 32'h6666_0000 + 32'(budget));
            stepCycle();
            if (accepted != 4'b0000) begin
                check_eq($sformatf("rr_order_%0d", n_grant), 32'(arid), 32'(n_grant % 4));
                n_grant++;
            end
            budget++;
        end
        if (n_grant < 8) check_eq("rr_order_timeout", 32'(n_grant), 32'd8);

        $display("[TB] randomized traffic");
        req_valid = 4'b0000;
        for (int c = 0; c < 1000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && $urandom_range(3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_addr[i*32 +: 32] = $urandom;
                end
            end
            arready = 1'($urandom_range(1));
            rvalid  = 1'($urandom_range(1));
            rlast   = ($urandom_range(2) == 0);
            rid     = ($urandom_range(15) == 0) ? 4'($urandom) : 4'(m_win);
            rdata   = $urandom;
            stepCycle();
        end

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
